// File: rtl/conv_pkg.sv
// Shared definitions for the conv address generator: default widths,
// channel tile size and FSM state encodings.
package conv_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DIM_W_DEF  = 8;
  localparam int TILE_C_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/conv_addr_gen_loop_ctr.sv
// One level of the loop nest: counts 0..max_i, advancing on en_i.
// wrap_o marks the enabled step that rolls the counter back to 0 and
// is used as the enable of the next outer level.
module addr_loop_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == max_i);
  assign wrap_o   = en_i && at_max_o;

  // Next count: clear has priority, then wrap-or-increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = at_max_o ? '0 : cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/conv_addr_gen.sv
// Convolution layer address walker. Emits one (IFM, filter) byte address
// pair per channel tile, loop order oy/ox/ky/kx/t. Addresses advance by
// adds only: steps are multiplied once when the layer is started.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int TILE_C = TILE_C_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] flt_base,
  input  logic [DIM_W-1:0]  ifm_w,
  input  logic [DIM_W-1:0]  ifm_c,
  input  logic [DIM_W-1:0]  ofm_w,
  input  logic [DIM_W-1:0]  ofm_h,
  input  logic [DIM_W-1:0]  kernel_w,
  input  logic [DIM_W-1:0]  kernel_h,
  input  logic [1:0]        stride,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] flt_addr,
  output logic              last_tile,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] TILE_INC = ADDR_W'(TILE_C);

  logic [1:0]        state_q, state_d;
  // latched loop limits (count maxima)
  logic [DIM_W-1:0]  mt_q, mkx_q, mky_q, mox_q, moy_q;
  logic [DIM_W-1:0]  mt_d, mkx_d, mky_d, mox_d, moy_d;
  // latched address steps: next kernel row, next window, next OFM row
  logic [ADDR_W-1:0] row_step_q, px_step_q, ln_step_q, flt_base_q;
  logic [ADDR_W-1:0] row_step_d, px_step_d, ln_step_d, flt_base_d;
  // running address registers: current beat, kernel row, window, OFM row
  logic [ADDR_W-1:0] ifm_q, flt_q, row_q, pix_q, line_q;
  logic [ADDR_W-1:0] ifm_d, flt_d, row_d, pix_d, line_d;

  logic [DIM_W-1:0]  tiles, s_dim;
  logic [ADDR_W-1:0] w_ext, c_ext, s_ext, wc;
  logic              zero_cfg, clr, fire;
  logic              at_t, at_kx, at_ky, at_ox, at_oy;
  logic              wr_t, wr_kx, wr_ky, wr_ox, wr_oy;
  logic [DIM_W-1:0]  c_t, c_kx, c_ky, c_ox, c_oy;

  assign tiles    = ifm_c / DIM_W'(TILE_C);
  assign s_dim    = (stride == 2'd0) ? DIM_W'(1) : DIM_W'(stride);
  assign w_ext    = ADDR_W'(ifm_w);
  assign c_ext    = ADDR_W'(ifm_c);
  assign s_ext    = ADDR_W'(s_dim);
  assign wc       = w_ext * c_ext;
  assign zero_cfg = (kernel_w == '0) || (kernel_h == '0) || (ofm_w == '0) ||
                    (ofm_h == '0) || (ifm_c < DIM_W'(TILE_C));
  assign clr      = (state_q == ST_IDLE) && start;
  assign fire     = (state_q == ST_RUN) && addr_ready;

  addr_loop_ctr #(.W(DIM_W)) u_t  (.clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(fire),
    .max_i(mt_q),  .cnt_o(c_t),  .at_max_o(at_t),  .wrap_o(wr_t));
  addr_loop_ctr #(.W(DIM_W)) u_kx (.clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(wr_t),
    .max_i(mkx_q), .cnt_o(c_kx), .at_max_o(at_kx), .wrap_o(wr_kx));
  addr_loop_ctr #(.W(DIM_W)) u_ky (.clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(wr_kx),
    .max_i(mky_q), .cnt_o(c_ky), .at_max_o(at_ky), .wrap_o(wr_ky));
  addr_loop_ctr #(.W(DIM_W)) u_ox (.clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(wr_ky),
    .max_i(mox_q), .cnt_o(c_ox), .at_max_o(at_ox), .wrap_o(wr_ox));
  addr_loop_ctr #(.W(DIM_W)) u_oy (.clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(wr_ox),
    .max_i(moy_q), .cnt_o(c_oy), .at_max_o(at_oy), .wrap_o(wr_oy));

  assign addr_valid = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign ifm_addr   = ifm_q;
  assign flt_addr   = flt_q;
  assign last_tile  = (state_q == ST_RUN) && at_t && at_kx && at_ky;

  // FSM plus config latch and incremental address update.
  // Within a kernel row IFM tiles are contiguous, so both addresses just
  // add TILE_C; row/window/OFM-row wraps reload from the held start regs.
  always_comb begin
    state_d    = state_q;
    mt_d = mt_q; mkx_d = mkx_q; mky_d = mky_q; mox_d = mox_q; moy_d = moy_q;
    row_step_d = row_step_q; px_step_d = px_step_q; ln_step_d = ln_step_q;
    flt_base_d = flt_base_q;
    ifm_d = ifm_q; flt_d = flt_q; row_d = row_q; pix_d = pix_q; line_d = line_q;
    case (state_q)
      ST_IDLE: if (start) begin
        mt_d       = tiles - DIM_W'(1);
        mkx_d      = kernel_w - DIM_W'(1);
        mky_d      = kernel_h - DIM_W'(1);
        mox_d      = ofm_w - DIM_W'(1);
        moy_d      = ofm_h - DIM_W'(1);
        row_step_d = wc;
        px_step_d  = s_ext * c_ext;
        ln_step_d  = s_ext * wc;
        flt_base_d = flt_base;
        ifm_d = ifm_base; row_d = ifm_base; pix_d = ifm_base; line_d = ifm_base;
        flt_d = flt_base;
        state_d = zero_cfg ? ST_DONE : ST_RUN;
      end
      ST_RUN: if (fire) begin
        if (wr_oy) begin
          state_d = ST_DONE;
        end else if (wr_ox) begin
          line_d = line_q + ln_step_q;
          pix_d  = line_q + ln_step_q;
          row_d  = line_q + ln_step_q;
          ifm_d  = line_q + ln_step_q;
          flt_d  = flt_base_q;
        end else if (wr_ky) begin
          pix_d = pix_q + px_step_q;
          row_d = pix_q + px_step_q;
          ifm_d = pix_q + px_step_q;
          flt_d = flt_base_q;
        end else if (wr_kx) begin
          row_d = row_q + row_step_q;
          ifm_d = row_q + row_step_q;
          flt_d = flt_q + TILE_INC;
        end else begin
          ifm_d = ifm_q + TILE_INC;
          flt_d = flt_q + TILE_INC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, config and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mt_q <= '0; mkx_q <= '0; mky_q <= '0; mox_q <= '0; moy_q <= '0;
      row_step_q <= '0; px_step_q <= '0; ln_step_q <= '0; flt_base_q <= '0;
      ifm_q <= '0; flt_q <= '0; row_q <= '0; pix_q <= '0; line_q <= '0;
    end else begin
      state_q <= state_d;
      mt_q <= mt_d; mkx_q <= mkx_d; mky_q <= mky_d; mox_q <= mox_d; moy_q <= moy_d;
      row_step_q <= row_step_d; px_step_q <= px_step_d; ln_step_q <= ln_step_d;
      flt_base_q <= flt_base_d;
      ifm_q <= ifm_d; flt_q <= flt_d; row_q <= row_d; pix_q <= pix_d; line_q <= line_d;
    end
  end
endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen: a loop-nest model fills a scoreboard
// with expected beats, which are popped as the DUT fires them.
module tb_conv_addr_gen;
  logic        clk, rst_n, start, addr_ready;
  logic [31:0] ifm_base, flt_base;
  logic [7:0]  ifm_w, ifm_c, ofm_w, ofm_h, kernel_w, kernel_h;
  logic [1:0]  stride;
  logic        addr_valid, last_tile, busy, done;
  logic [31:0] ifm_addr, flt_addr;

  typedef struct { logic [31:0] ifm; logic [31:0] flt; logic last; } beat_t;
  beat_t sb[$];
  int nerr = 0;
  int nchk = 0;

  conv_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ifm_base(ifm_base), .flt_base(flt_base),
    .ifm_w(ifm_w), .ifm_c(ifm_c), .ofm_w(ofm_w), .ofm_h(ofm_h),
    .kernel_w(kernel_w), .kernel_h(kernel_h), .stride(stride),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .ifm_addr(ifm_addr), .flt_addr(flt_addr),
    .last_tile(last_tile), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] ib, input logic [31:0] fb, input int w,
                         input int c, input int ow, input int oh, input int kw,
                         input int kh, input int s);
    ifm_base = ib; flt_base = fb;
    ifm_w = 8'(w); ifm_c = 8'(c); ofm_w = 8'(ow); ofm_h = 8'(oh);
    kernel_w = 8'(kw); kernel_h = 8'(kh); stride = 2'(s);
  endtask

  // Reference loop nest straight from the address formulas.
  task automatic gen();
    int s, nt;
    beat_t b;
    s  = (stride == 0) ? 1 : int'(stride);
    nt = int'(ifm_c) / 4;
    sb.delete();
    if (kernel_w == 0 || kernel_h == 0 || ofm_w == 0 || ofm_h == 0 || ifm_c < 4) return;
    for (int oy = 0; oy < int'(ofm_h); oy++)
      for (int ox = 0; ox < int'(ofm_w); ox++)
        for (int ky = 0; ky < int'(kernel_h); ky++)
          for (int kx = 0; kx < int'(kernel_w); kx++)
            for (int t = 0; t < nt; t++) begin
              b.ifm  = ifm_base + 32'(((oy*s + ky)*int'(ifm_w) + ox*s + kx)*int'(ifm_c) + t*4);
              b.flt  = flt_base + 32'((ky*int'(kernel_w) + kx)*int'(ifm_c) + t*4);
              b.last = (t == nt-1) && (kx == int'(kernel_w)-1) && (ky == int'(kernel_h)-1);
              sb.push_back(b);
            end
  endtask

  // Starts the configured layer and drains it against the scoreboard.
  // abort_n>0 resets the DUT right after that many beats; busy_start pulses
  // start (with a different base) in the middle of the run.
  task automatic run_layer(input bit rnd, input int abort_n, input bit busy_start,
                           input int exp_beats);
    int fired = 0;
    int cyc = 0;
    bit fin = 0;
    bit abort = 0;
    bit stalled = 0;
    bit exp_done;
    beat_t hold, b;
    logic hold_v;
    gen();
    chk("model_beats", 64'(sb.size()), 64'(exp_beats));
    exp_done = (exp_beats == 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 2000) begin
      chk("done", 64'(done), 64'(exp_done));
      if (exp_done) begin
        chk("valid_at_done", 64'(addr_valid), 64'(0));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("beats_fired", 64'(fired), 64'(exp_beats));
        chk("sb_empty", 64'(sb.size()), 64'(0));
        fin = 1;
      end else begin
        chk("valid", 64'(addr_valid), 64'(1));
        chk("busy", 64'(busy), 64'(1));
        if (stalled) begin
          chk("hold_ifm", 64'(ifm_addr), 64'(hold.ifm));
          chk("hold_flt", 64'(flt_addr), 64'(hold.flt));
          chk("hold_last", 64'(last_tile), 64'(hold.last));
        end
        if (busy_start && cyc == 2) begin start = 1'b1; ifm_base = 32'h5000; end
        if (busy_start && cyc == 3) start = 1'b0;
        addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (addr_ready) begin
          if (sb.size() == 0) begin
            chk("extra_beat", 64'(1), 64'(0));
            fin = 1;
          end else begin
            b = sb.pop_front();
            chk("ifm_addr", 64'(ifm_addr), 64'(b.ifm));
            chk("flt_addr", 64'(flt_addr), 64'(b.flt));
            chk("last_tile", 64'(last_tile), 64'(b.last));
            fired++;
            exp_done = (sb.size() == 0);
            if (abort_n > 0 && fired == abort_n) begin abort = 1; fin = 1; end
          end
        end
        stalled = !addr_ready;
        hold.ifm = ifm_addr; hold.flt = flt_addr; hold.last = last_tile;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("cycle_budget", 64'(0), 64'(1));
    if (abort) begin
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(addr_valid), 64'(0));
      chk("rst_ifm", 64'(ifm_addr), 64'(0));
      chk("rst_flt", 64'(flt_addr), 64'(0));
      chk("rst_last", 64'(last_tile), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("no_done_after_rst", 64'(done), 64'(0));
        chk("idle_after_rst", 64'(busy), 64'(0));
      end
      sb.delete();
    end else begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      hold_v = addr_valid;
      chk("idle_valid", 64'(hold_v), 64'(0));
    end
    addr_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; addr_ready = 1'b1;
    set_cfg(32'h0, 32'h0, 1, 4, 1, 1, 1, 1, 1);
    #12;
    chk("reset_valid", 64'(addr_valid), 64'(0));
    chk("reset_ifm", 64'(ifm_addr), 64'(0));
    chk("reset_flt", 64'(flt_addr), 64'(0));
    chk("reset_last", 64'(last_tile), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // minimal 1x1 layer
    set_cfg(32'h100, 32'h800, 2, 4, 2, 2, 1, 1, 1);
    run_layer(0, 0, 0, 4);
    // tiled 3x3 window, full throughput
    set_cfg(32'h0, 32'h0, 4, 8, 2, 2, 3, 3, 1);
    run_layer(0, 0, 0, 72);
    // stride 2
    set_cfg(32'h0, 32'h0, 6, 4, 2, 2, 2, 2, 2);
    run_layer(0, 0, 0, 16);
    // tiled 3x3 under random backpressure
    set_cfg(32'h0, 32'h0, 4, 8, 2, 2, 3, 3, 1);
    run_layer(1, 0, 0, 72);
    // zero-size kernel: no beats, immediate done
    set_cfg(32'h0, 32'h0, 4, 8, 2, 2, 0, 3, 1);
    run_layer(0, 0, 0, 0);
    // reset after 5 beats, then restart with start pulsed while busy
    set_cfg(32'h40, 32'h200, 4, 8, 2, 2, 3, 3, 1);
    run_layer(1, 5, 0, 72);
    set_cfg(32'h40, 32'h200, 4, 8, 2, 2, 3, 3, 1);
    run_layer(1, 0, 1, 72);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/conv_addr_gen.md
# conv_addr_gen

Parametrised address generator for the fused-block CNN datapath. It walks one convolution layer and emits paired IFM and filter byte addresses, one channel tile (TILE_C channels per word) per beat. Each beat uses a valid/ready handshake toward the memory request port. Compared with the earlier generator it adds configurable stride, kernel height/width, channel-tile count and backpressure, plus per-window and end-of-layer markers.

## Interface
- ADDR_W, 32, address width (bytes)
- DIM_W, 8, width of every dimension/config field
- TILE_C, 4, channels per fetched word; also the byte increment per tile (1 byte/channel)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin layer; sampled only in IDLE
- ifm_base  in  ADDR_W  IFM base byte address (HWC layout)
- flt_base  in  ADDR_W  filter base byte address (KyKxC layout, one output filter)
- ifm_w  in  DIM_W  IFM width (pixels)
- ifm_c  in  DIM_W  IFM channels; multiple of TILE_C
- ofm_w, ofm_h  in  DIM_W  OFM width/height
- kernel_w, kernel_h  in  DIM_W  kernel size
- stride  in  2  stride (0 treated as 1)
- addr_valid  out  1  beat available
- addr_ready  in  1  consumer accepts beat
- ifm_addr, flt_addr  out  ADDR_W  beat addresses
- last_tile  out  1  beat is final beat of current OFM pixel window
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch all config inputs. Go to RUN. If any of kernel_w, kernel_h, ofm_w, ofm_h is 0, or ifm_c < TILE_C, go to DONE instead (zero beats).
- Loop nest, outermost first: oy (0..ofm_h-1), ox (0..ofm_w-1), ky (0..kernel_h-1), kx (0..kernel_w-1), t (0..ifm_c/TILE_C-1).
- ifm_addr = ifm_base + ((oy*S+ky)*ifm_w + ox*S+kx)*ifm_c + t*TILE_C.
- flt_addr = flt_base + (ky*kernel_w+kx)*ifm_c + t*TILE_C.
- Addresses are computed incrementally from held row/window/pixel start registers; no per-beat multiplier on the output path.
- All arithmetic wraps modulo 2^ADDR_W.
- A fire is addr_valid && addr_ready; the counters advance only on a fire.
- last_tile = (t,kx,ky) all at their maximum.
- The final fire (all five counters at max) moves the block to DONE.
- DONE: assert done for one cycle, then return to IDLE.
- start is ignored while busy. Config changes after start have no effect.
- No padding; the caller guarantees the windows stay inside the IFM.

## Timing
- Reset values: addr_valid=0, ifm_addr=0, flt_addr=0, last_tile=0, busy=0, done=0; state IDLE.
- start at edge n: busy=1 and addr_valid=1 with the first beat from edge n+1.
- Throughput is one beat per cycle while addr_ready=1.
- With addr_valid=1 and addr_ready=0, ifm_addr, flt_addr and last_tile hold stable. addr_valid never drops without a fire.
- Final fire at edge m: addr_valid=0 and busy=0 at m+1, with done=1 at m+1 only.
- Zero-size config: done pulses on the cycle after start, and addr_valid never rises.
- rst_n asserted mid-run: immediate return to reset values. No done is generated.

## Structure
- Shared package conv_pkg: state enum, DIM_W/ADDR_W defaults, TILE_C.
- One sub-module, addr_loop_ctr: a wrap counter with a max input, enable input and wrap output. It is instanced five times (t, kx, ky, ox, oy). The address accumulators stay in the top module.

## Test plan
- Minimal layer: kernel 1x1, ifm_c=4, ifm_w=2, ofm 2x2, stride 1, ifm_base=0x100, flt_base=0x800, ready=1.
  - ifm_addr is 0x100, 0x104, 0x108, 0x10C; flt_addr is 0x800 on every beat.
  - last_tile is high on every beat; done pulses one cycle after the 4th beat.
- Tiled 3x3 window: kernel 3x3, ifm_c=8, ifm_w=4, ofm 2x2, stride 1, bases 0.
  - Window 0 has 18 beats: ifm 0,4,8,12,16,20,32,36,…,84; flt 0..68 step 4. last_tile is high on beat 18.
  - Window 1 starts at ifm 8; window 2 starts at 32.
- Stride 2: kernel 2x2, ifm_c=4, ifm_w=6, ofm 2x2, bases 0.
  - Windows start at ifm 0, 8, 48, 56. Total 16 beats.
- Backpressure: rerun the tiled 3x3 case with addr_ready toggling pseudo-randomly.
  - The beat sequence is identical to the ready=1 run. Outputs hold stable while stalled. done pulses exactly once.
- Zero config: kernel_w=0 with start=1.
  - No addr_valid; done=1 on the next cycle; busy then 0.
- Reset and restart: drop rst_n after 5 beats.
  - All outputs return to reset values.
  - A new start then produces the first beat at ifm_base again. start pulsed while busy is ignored.
